// File: rtl/fabric_load_check.sv
// fabric_load_check: streams a bitstream into the eFPGA self-write port, pulses the fabric reset,
// then compares fabric outputs against a gold netlist in lockstep. Define LOAD_CHECK_TRISTATE_EN to include output enables.
module fabric_load_check #(
  parameter int unsigned IO_WIDTH      = 28,
  parameter int unsigned BYTE_COUNT    = 16384,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned RESET_CYCLES  = 5,
  parameter int unsigned CHECK_CYCLES  = 100,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [7:0]           byte_data,
  output logic [31:0]          SelfWriteData,
  output logic                 SelfWriteStrobe,
  output logic [IO_WIDTH-1:0]  stim_out,
  input  logic [IO_WIDTH-1:0]  fabric_i,
  input  logic [IO_WIDTH-1:0]  gold_i,
  input  logic [IO_WIDTH-1:0]  fabric_t,
  input  logic [IO_WIDTH-1:0]  gold_t,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 first_err_valid,
  output logic [CNT_WIDTH-1:0] first_err_cycle
);

  localparam int unsigned WORDS  = BYTE_COUNT / 4;
  localparam int unsigned WORD_W = $clog2(WORDS + 1);
  localparam int unsigned MAX_A  = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_B  = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
  localparam int unsigned MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned PH_MAX = (MAX_C > CHECK_CYCLES) ? MAX_C : CHECK_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PACK, S_SETUP, S_STROBE, S_GAP, S_SETTLE, S_RST, S_CHECK, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [PH_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]     words_q, words_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           pack_q, pack_d;
  logic [31:0]           swd_q, swd_d;
  logic                  strobe_q, strobe_d;
  logic                  byte_ready_q, byte_ready_d;
  logic [IO_WIDTH-1:0]   stim_q, stim_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic                  fev_q, fev_d;
  logic [CNT_WIDTH-1:0]  fec_q, fec_d;
  logic                  mismatch_c;

`ifdef LOAD_CHECK_TRISTATE_EN
  assign mismatch_c = (fabric_i != gold_i) || (fabric_t != gold_t);
`else
  logic unused_t;
  assign mismatch_c = (fabric_i != gold_i);
  assign unused_t   = ^{fabric_t, gold_t};
`endif

  // State register and all registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      words_q      <= '0;
      byte_idx_q   <= '0;
      pack_q       <= '0;
      swd_q        <= '0;
      strobe_q     <= 1'b0;
      byte_ready_q <= 1'b0;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fev_q        <= 1'b0;
      fec_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_q      <= words_d;
      byte_idx_q   <= byte_idx_d;
      pack_q       <= pack_d;
      swd_q        <= swd_d;
      strobe_q     <= strobe_d;
      byte_ready_q <= byte_ready_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fev_q        <= fev_d;
      fec_q        <= fec_d;
    end
  end

  // Next-state, datapath and output decode; outputs follow the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    swd_d      = swd_q;
    err_d      = err_q;
    fev_d      = fev_q;
    fec_d      = fec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_PACK;
          cnt_d      = '0;
          words_d    = '0;
          byte_idx_d = '0;
          pack_d     = '0;
          swd_d      = '0;
          err_d      = '0;
          fev_d      = 1'b0;
          fec_d      = '0;
        end
      end
      S_PACK: begin
        if (byte_valid && byte_ready_q) begin
          pack_d     = {pack_q[15:0], byte_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            swd_d   = {pack_q, byte_data};
            words_d = words_q + WORD_W'(1);
            cnt_d   = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == PH_W'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      S_STROBE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == PH_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (words_q == WORD_W'(WORDS)) ? S_SETTLE : S_PACK;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == PH_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RST;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      S_RST: begin
        if (cnt_q == PH_W'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      S_CHECK: begin
        // cnt_q doubles as the 0-based window index of the current sample.
        if (mismatch_c) begin
          if (err_q != '1) begin
            err_d = err_q + CNT_WIDTH'(1);
          end
          if (!fev_q) begin
            fev_d = 1'b1;
            fec_d = CNT_WIDTH'(cnt_q);
          end
        end
        if (cnt_q == PH_W'(CHECK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_PACK);
    strobe_d     = (state_d == S_STROBE);
    stim_d       = (state_d == S_RST) ? IO_WIDTH'(1) : '0;
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    pass_d       = (state_d == S_DONE) && (err_d == '0);
  end

  assign byte_ready      = byte_ready_q;
  assign SelfWriteData   = swd_q;
  assign SelfWriteStrobe = strobe_q;
  assign stim_out        = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_cycle = fec_q;

endmodule
